free_list_decoder_64: RTL and testbench

- Tracks occupancy of 64 allocatable entries (physical registers / queue slots) as a registered free mask.
- Sits on the opposite side of the 64-input priority encoder:
  - the encoder picks a free entry and emits its 6-bit index;
  - this block decodes allocate and release indices back to one-hot, updates the mask, and feeds the mask back to the encoder's inputs.
- Also maintains a free count and flags illegal allocate/release operations.

---
 rtl/free_list_decoder_64_pkg.sv | 20 ++
 rtl/index_onehot_decoder_64.sv | 19 +
 rtl/free_list_decoder_64.sv | 96 +++++++++
 tb/tb_free_list_decoder_64.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_decoder_64_pkg.sv
// Shared types and helpers for the 64-entry free-list tracker.
// Entries below the reserved count start busy; all others start free.
package free_list_decoder_64_pkg;

    localparam int FREE_ENTRIES = 64;
    localparam int FREE_INDEX_W = 6;

    typedef logic [FREE_INDEX_W-1:0] free_index_t;
    typedef logic [6:0]              free_count_t;

    // Reset/flush image in "1 = free" form, independent of mask polarity.
    function automatic logic [FREE_ENTRIES-1:0] reset_free_image(input int num_reserved);
        logic [FREE_ENTRIES-1:0] img;
        for (int i = 0; i < FREE_ENTRIES; i++) begin
            img[i] = (i >= num_reserved);
        end
        return img;
    endfunction

endpackage

// File: rtl/index_onehot_decoder_64.sv
// Combinational 6-bit index to 64-bit one-hot decoder with enable.
// An inactive enable yields an all-zero vector.
module index_onehot_decoder_64
    import free_list_decoder_64_pkg::*;
(
    input  free_index_t              i_index,
    input  logic                     i_enable,
    output logic [FREE_ENTRIES-1:0]  o_onehot
);

    always_comb begin
        // NOTE: every output gets a default before any condition, so no latch is inferred.
        o_onehot = '0;
        if (i_enable) begin
            o_onehot[i_index] = 1'b1;
        end
    end

endmodule

// File: rtl/free_list_decoder_64.sv
// Registered free mask, free count and error flags for 64 allocatable entries.
// Feeds the mask back to a priority encoder that picks the next free entry.
module free_list_decoder_64
    import free_list_decoder_64_pkg::*;
#(
    parameter logic SIGNAL       = 1'b1,
    parameter int   NUM_RESERVED = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        alloc_valid,
    input  free_index_t alloc_index,
    input  logic        release_valid,
    input  free_index_t release_index,
    output logic        free_mask [FREE_ENTRIES-1:0],
    output free_count_t free_count,
    output logic        empty,
    output logic        alloc_error,
    output logic        release_error
);

    localparam logic [FREE_ENTRIES-1:0] RESET_FREE  = reset_free_image(NUM_RESERVED);
    localparam free_count_t             RESET_COUNT = free_count_t'(FREE_ENTRIES - NUM_RESERVED);

    logic [FREE_ENTRIES-1:0] r_free;
    free_count_t             r_count;
    logic                    r_empty;
    logic                    r_alloc_error;
    logic                    r_release_error;

    logic [FREE_ENTRIES-1:0] w_release_onehot;
    logic [FREE_ENTRIES-1:0] w_alloc_onehot;
    logic [FREE_ENTRIES-1:0] w_free_after_release;
    logic [FREE_ENTRIES-1:0] w_free_next;
    logic                    w_release_ok;
    logic                    w_alloc_ok;
    free_count_t             w_count_next;

    index_onehot_decoder_64 u_release_dec (
        .i_index  (release_index),
        .i_enable (release_valid),
        .o_onehot (w_release_onehot)
    );

    index_onehot_decoder_64 u_alloc_dec (
        .i_index  (alloc_index),
        .i_enable (alloc_valid),
        .o_onehot (w_alloc_onehot)
    );

    // Alloc is judged against the mask after this cycle's release has been applied.
    always_comb begin
        w_release_ok         = (|(w_release_onehot & ~r_free)) &&
                               (int'(release_index) >= NUM_RESERVED);
        w_free_after_release = r_free | (w_release_onehot & {FREE_ENTRIES{w_release_ok}});
        w_alloc_ok           = |(w_alloc_onehot & w_free_after_release);
        w_free_next          = w_free_after_release & ~(w_alloc_onehot & {FREE_ENTRIES{w_alloc_ok}});
        w_count_next         = r_count + free_count_t'(w_release_ok) - free_count_t'(w_alloc_ok);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free          <= RESET_FREE;
            r_count         <= RESET_COUNT;
            r_empty         <= (RESET_COUNT == '0);
            r_alloc_error   <= 1'b0;
            r_release_error <= 1'b0;
        end else if (flush) begin
            r_free          <= RESET_FREE;
            r_count         <= RESET_COUNT;
            r_empty         <= (RESET_COUNT == '0);
            r_alloc_error   <= 1'b0;
            r_release_error <= 1'b0;
        end else begin
            r_free          <= w_free_next;
            r_count         <= w_count_next;
            r_empty         <= (w_count_next == '0);
            r_alloc_error   <= alloc_valid && !w_alloc_ok;
            r_release_error <= release_valid && !w_release_ok;
        end
    end

    always_comb begin
        for (int i = 0; i < FREE_ENTRIES; i++) begin
            free_mask[i] = SIGNAL ? r_free[i] : ~r_free[i];
        end
    end

    assign free_count    = r_count;
    assign empty         = r_empty;
    assign alloc_error   = r_alloc_error;
    assign release_error = r_release_error;

endmodule

// File: tb/tb_free_list_decoder_64.sv
// Directed bench for free_list_decoder_64 with three parameterisations sharing one stimulus bus.
// A behavioural lowest-index priority encoder closes the allocation loop.
module tb_free_list_decoder_64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       alloc_valid;
    logic [5:0] alloc_index;
    logic       release_valid;
    logic [5:0] release_index;

    // dut0: SIGNAL=1, NUM_RESERVED=0; dut8: SIGNAL=0, NUM_RESERVED=8; dut32: SIGNAL=1, NUM_RESERVED=32
    logic       m0 [63:0];
    logic       m8 [63:0];
    logic       m32 [63:0];
    logic [6:0] c0, c8, c32;
    logic       e0, e8, e32;
    logic       ae0, ae8, ae32;
    logic       re0, re8, re32;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    free_list_decoder_64 #(.SIGNAL(1'b1), .NUM_RESERVED(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_index(alloc_index),
        .release_valid(release_valid), .release_index(release_index),
        .free_mask(m0), .free_count(c0), .empty(e0),
        .alloc_error(ae0), .release_error(re0)
    );

    free_list_decoder_64 #(.SIGNAL(1'b0), .NUM_RESERVED(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_index(alloc_index),
        .release_valid(release_valid), .release_index(release_index),
        .free_mask(m8), .free_count(c8), .empty(e8),
        .alloc_error(ae8), .release_error(re8)
    );

    free_list_decoder_64 #(.SIGNAL(1'b1), .NUM_RESERVED(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_index(alloc_index),
        .release_valid(release_valid), .release_index(release_index),
        .free_mask(m32), .free_count(c32), .empty(e32),
        .alloc_error(ae32), .release_error(re32)
    );

    function automatic logic [63:0] pack(input logic m [63:0]);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = m[i];
        return v;
    endfunction

    function automatic logic [6:0] count_sig(input logic [63:0] v, input logic sig);
        logic [6:0] n = '0;
        for (int i = 0; i < 64; i++) if (v[i] === sig) n = n + 7'd1;
        return n;
    endfunction

    // Lowest-index-first priority encoder; returns 0 when nothing is free.
    function automatic logic [5:0] lowest_free(input logic [63:0] v, input logic sig);
        for (int i = 0; i < 64; i++) if (v[i] === sig) return 6'(i);
        return 6'd0;
    endfunction

    // Count must always agree with the population of free bits in the mask.
    always @(negedge clk) begin
        checks = checks + 3;
        if (count_sig(pack(m0), 1'b1) !== c0) begin
            failures++; $display("FAIL invariant_dut0 count=%0d mask_free=%0d", c0, count_sig(pack(m0), 1'b1));
        end
        if (count_sig(pack(m8), 1'b0) !== c8) begin
            failures++; $display("FAIL invariant_dut8 count=%0d mask_free=%0d", c8, count_sig(pack(m8), 1'b0));
        end
        if (count_sig(pack(m32), 1'b1) !== c32) begin
            failures++; $display("FAIL invariant_dut32 count=%0d mask_free=%0d", c32, count_sig(pack(m32), 1'b1));
        end
    end

    task automatic idle();
        flush = 1'b0; alloc_valid = 1'b0; release_valid = 1'b0;
        alloc_index = 6'd0; release_index = 6'd0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; cycle(); idle();
    endtask

    task automatic test_reset();
        logic [63:0] exp32, exp8;
        for (int i = 0; i < 64; i++) begin
            exp32[i] = (i >= 32);
            exp8[i]  = (i < 8);
        end
        rst_n = 1'b0; idle(); #2;
        for (int k = 0; k < 2; k++) begin
            checks = checks + 8;
            if (pack(m32) !== exp32) begin failures++; $display("FAIL reset_mask32 got=%h exp=%h", pack(m32), exp32); end
            if (c32 !== 7'd32)       begin failures++; $display("FAIL reset_count32 got=%0d exp=32", c32); end
            if (e32 !== 1'b0)        begin failures++; $display("FAIL reset_empty32 got=%b exp=0", e32); end
            if (ae32 !== 1'b0)       begin failures++; $display("FAIL reset_alloc_err32 got=%b exp=0", ae32); end
            if (re32 !== 1'b0)       begin failures++; $display("FAIL reset_release_err32 got=%b exp=0", re32); end
            if (c0 !== 7'd64)        begin failures++; $display("FAIL reset_count0 got=%0d exp=64", c0); end
            if (c8 !== 7'd56)        begin failures++; $display("FAIL reset_count8 got=%0d exp=56", c8); end
            if (pack(m8) !== exp8)   begin failures++; $display("FAIL reset_mask8 got=%h exp=%h", pack(m8), exp8); end
            cycle();
        end
        rst_n = 1'b1; cycle();
        checks = checks + 2;
        if (pack(m32) !== exp32) begin failures++; $display("FAIL post_reset_mask32 got=%h exp=%h", pack(m32), exp32); end
        if (c32 !== 7'd32)       begin failures++; $display("FAIL post_reset_count32 got=%0d exp=32", c32); end
    endtask

    task automatic test_alloc_burst();
        logic [5:0] enc;
        for (int i = 0; i < 64; i++) begin
            enc = lowest_free(pack(m0), 1'b1);
            checks++;
            if (enc !== 6'(i)) begin failures++; $display("FAIL burst_index step=%0d got=%0d exp=%0d", i, enc, i); end
            alloc_valid = 1'b1; alloc_index = enc;
            cycle();
            checks++;
            if (c0 !== 7'(63 - i)) begin failures++; $display("FAIL burst_count step=%0d got=%0d exp=%0d", i, c0, 63 - i); end
        end
        checks = checks + 2;
        if (e0 !== 1'b1)  begin failures++; $display("FAIL burst_empty got=%b exp=1", e0); end
        if (ae0 !== 1'b0) begin failures++; $display("FAIL burst_no_err got=%b exp=0", ae0); end
        alloc_index = 6'd5; cycle();
        checks = checks + 3;
        if (ae0 !== 1'b1) begin failures++; $display("FAIL overalloc_err got=%b exp=1", ae0); end
        if (c0 !== 7'd0)  begin failures++; $display("FAIL overalloc_count got=%0d exp=0", c0); end
        if (e0 !== 1'b1)  begin failures++; $display("FAIL overalloc_empty got=%b exp=1", e0); end
        idle(); cycle();
        checks++;
        if (ae0 !== 1'b0) begin failures++; $display("FAIL overalloc_pulse got=%b exp=0", ae0); end
        do_flush();
        checks++;
        if (c0 !== 7'd64) begin failures++; $display("FAIL burst_flush_count got=%0d exp=64", c0); end
    endtask

    task automatic test_same_index();
        alloc_valid = 1'b1; alloc_index = 6'd10; cycle();
        checks++;
        if (c0 !== 7'd63) begin failures++; $display("FAIL same_setup_count got=%0d exp=63", c0); end
        release_valid = 1'b1; release_index = 6'd10; cycle();
        checks = checks + 4;
        if (m0[10] !== 1'b0) begin failures++; $display("FAIL same_busy_bit got=%b exp=0", m0[10]); end
        if (c0 !== 7'd63)    begin failures++; $display("FAIL same_busy_count got=%0d exp=63", c0); end
        if (ae0 !== 1'b0)    begin failures++; $display("FAIL same_busy_alloc_err got=%b exp=0", ae0); end
        if (re0 !== 1'b0)    begin failures++; $display("FAIL same_busy_release_err got=%b exp=0", re0); end
        alloc_index = 6'd11; release_index = 6'd11; cycle();
        checks = checks + 4;
        if (re0 !== 1'b1)    begin failures++; $display("FAIL same_free_release_err got=%b exp=1", re0); end
        if (ae0 !== 1'b0)    begin failures++; $display("FAIL same_free_alloc_err got=%b exp=0", ae0); end
        if (c0 !== 7'd62)    begin failures++; $display("FAIL same_free_count got=%0d exp=62", c0); end
        if (m0[11] !== 1'b0) begin failures++; $display("FAIL same_free_bit got=%b exp=0", m0[11]); end
        idle(); cycle();
        checks++;
        if (re0 !== 1'b0) begin failures++; $display("FAIL same_free_pulse got=%b exp=0", re0); end
        do_flush();
    endtask

    task automatic test_release_errors();
        release_valid = 1'b1; release_index = 6'd7; cycle();
        checks = checks + 2;
        if (re0 !== 1'b1) begin failures++; $display("FAIL rel_free_err got=%b exp=1", re0); end
        if (c0 !== 7'd64) begin failures++; $display("FAIL rel_free_count got=%0d exp=64", c0); end
        idle(); cycle();
        checks++;
        if (re0 !== 1'b0) begin failures++; $display("FAIL rel_free_pulse got=%b exp=0", re0); end
        release_valid = 1'b1; release_index = 6'd3; cycle();
        checks = checks + 3;
        if (re8 !== 1'b1)   begin failures++; $display("FAIL rel_reserved_err got=%b exp=1", re8); end
        if (c8 !== 7'd56)   begin failures++; $display("FAIL rel_reserved_count got=%0d exp=56", c8); end
        if (m8[3] !== 1'b1) begin failures++; $display("FAIL rel_reserved_bit got=%b exp=1", m8[3]); end
        idle(); alloc_valid = 1'b1; alloc_index = 6'd20; cycle();
        checks = checks + 3;
        if (c8 !== 7'd55)    begin failures++; $display("FAIL inv_alloc_count got=%0d exp=55", c8); end
        if (m8[20] !== 1'b1) begin failures++; $display("FAIL inv_alloc_bit got=%b exp=1", m8[20]); end
        if (ae8 !== 1'b0)    begin failures++; $display("FAIL inv_alloc_err got=%b exp=0", ae8); end
        idle(); release_valid = 1'b1; release_index = 6'd20; cycle();
        checks = checks + 3;
        if (c8 !== 7'd56)    begin failures++; $display("FAIL inv_release_count got=%0d exp=56", c8); end
        if (m8[20] !== 1'b0) begin failures++; $display("FAIL inv_release_bit got=%b exp=0", m8[20]); end
        if (re8 !== 1'b0)    begin failures++; $display("FAIL inv_release_err got=%b exp=0", re8); end
        do_flush();
    endtask

    task automatic test_flush();
        logic [63:0] exp32;
        for (int i = 0; i < 64; i++) exp32[i] = (i >= 32);
        alloc_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            alloc_index = 6'(32 + k); cycle();
        end
        checks = checks + 2;
        if (c0 !== 7'd44)  begin failures++; $display("FAIL flush_setup_count0 got=%0d exp=44", c0); end
        if (c32 !== 7'd12) begin failures++; $display("FAIL flush_setup_count32 got=%0d exp=12", c32); end
        alloc_index = 6'd32; cycle();
        checks++;
        if (ae0 !== 1'b1) begin failures++; $display("FAIL flush_setup_err got=%b exp=1", ae0); end
        flush = 1'b1; alloc_index = 6'd40; release_valid = 1'b1; release_index = 6'd33; cycle();
        idle();
        checks = checks + 7;
        if (c0 !== 7'd64)        begin failures++; $display("FAIL flush_count0 got=%0d exp=64", c0); end
        if (c32 !== 7'd32)       begin failures++; $display("FAIL flush_count32 got=%0d exp=32", c32); end
        if (m0[40] !== 1'b1)     begin failures++; $display("FAIL flush_bit40 got=%b exp=1", m0[40]); end
        if (pack(m32) !== exp32) begin failures++; $display("FAIL flush_mask32 got=%h exp=%h", pack(m32), exp32); end
        if (ae0 !== 1'b0)        begin failures++; $display("FAIL flush_alloc_err got=%b exp=0", ae0); end
        if (re0 !== 1'b0)        begin failures++; $display("FAIL flush_release_err got=%b exp=0", re0); end
        if (e32 !== 1'b0)        begin failures++; $display("FAIL flush_empty32 got=%b exp=0", e32); end
    endtask

    task automatic test_async_reset();
        alloc_valid = 1'b1; alloc_index = 6'd0; cycle();
        alloc_index = 6'd1; cycle();
        checks++;
        if (c0 !== 7'd62) begin failures++; $display("FAIL async_setup_count got=%0d exp=62", c0); end
        alloc_index = 6'd2;
        #3 rst_n = 1'b0;
        #1;
        checks = checks + 4;
        if (c0 !== 7'd64)                 begin failures++; $display("FAIL async_count0 got=%0d exp=64", c0); end
        if (pack(m0) !== {64{1'b1}})      begin failures++; $display("FAIL async_mask0 got=%h exp=all free", pack(m0)); end
        if (c32 !== 7'd32)                begin failures++; $display("FAIL async_count32 got=%0d exp=32", c32); end
        if (e0 !== 1'b0)                  begin failures++; $display("FAIL async_empty0 got=%b exp=0", e0); end
        cycle();
        checks++;
        if (c0 !== 7'd64) begin failures++; $display("FAIL async_hold_count got=%0d exp=64", c0); end
        rst_n = 1'b1; alloc_index = 6'd0; cycle();
        idle();
        checks = checks + 3;
        if (c0 !== 7'd63)   begin failures++; $display("FAIL async_first_alloc_count got=%0d exp=63", c0); end
        if (m0[0] !== 1'b0) begin failures++; $display("FAIL async_first_alloc_bit got=%b exp=0", m0[0]); end
        if (ae0 !== 1'b0)   begin failures++; $display("FAIL async_first_alloc_err got=%b exp=0", ae0); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        idle();
        #1;
        test_reset();
        test_alloc_burst();
        test_same_index();
        test_release_errors();
        test_flush();
        test_async_reset();
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
